// File: rtl/osc_freq_monitor.sv
// osc_freq_monitor: counts MON_CLK rising edges per CLK window and checks them
// against a tolerance band, giving a debounced good flag and a sticky fault.
module osc_freq_monitor #(
    parameter int WINDOW       = 1000,
    parameter int MIN_EDGES    = 18,
    parameter int MAX_EDGES    = 22,
    parameter int GOOD_WINDOWS = 3,
    parameter int CNT_W        = 16
) (
    input  logic             CLK,
    input  logic             RESETN,
    input  logic             MON_CLK,
    input  logic             ENABLE,
    input  logic             CLR_FAULT,
    output logic             FREQ_OK,
    output logic             FAULT,
    output logic             COUNT_VALID,
    output logic [CNT_W-1:0] EDGE_COUNT
);
    localparam int WW = $clog2(WINDOW);
    localparam int GW = $clog2(GOOD_WINDOWS + 1);
    localparam logic [WW-1:0] LAST = WW'(WINDOW - 1);
    localparam logic [GW-1:0] GOOD_MAX = GW'(GOOD_WINDOWS);
    localparam logic [CNT_W-1:0] SAT = '1;

    typedef enum logic [1:0] {IDLE, SETTLE, MEASURE} state_t;

    state_t state, state_nx;
    logic s1, s2, s3, mon_edge;
    logic [WW-1:0] win_cnt, win_nx;
    logic [CNT_W-1:0] edge_cnt, edge_nx, total;
    logic [GW-1:0] good_cnt, good_nx;
    logic win_end, in_range, report, ok_nx, fault_nx;

    assign mon_edge = s2 & ~s3;
    assign total    = edge_cnt == SAT ? SAT : edge_cnt + CNT_W'(mon_edge);
    assign in_range = 32'(total) >= 32'(MIN_EDGES) && 32'(total) <= 32'(MAX_EDGES);
    assign win_end  = win_cnt == LAST;
    assign report   = ENABLE && state == MEASURE && win_end;

    always_comb begin
        state_nx = state;
        win_nx   = '0;
        edge_nx  = '0;
        good_nx  = good_cnt;
        ok_nx    = FREQ_OK;
        // a new out-of-range result beats a coincident clear request
        fault_nx = report && !in_range ? 1'b1 : CLR_FAULT ? 1'b0 : FAULT;
        if (!ENABLE) begin
            state_nx = IDLE;
            good_nx  = '0;
            ok_nx    = 1'b0;
        end else if (state == IDLE) begin
            state_nx = SETTLE;
        end else begin
            win_nx  = win_end ? '0 : win_cnt + 1'b1;
            edge_nx = win_end ? '0 : total;
            if (win_end)
                state_nx = MEASURE;
            if (report) begin
                good_nx = !in_range ? '0 : good_cnt == GOOD_MAX ? good_cnt : good_cnt + 1'b1;
                ok_nx   = good_nx == GOOD_MAX;
            end
        end
    end

    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            {s1, s2, s3} <= '0;
            state        <= IDLE;
            win_cnt      <= '0;
            edge_cnt     <= '0;
            good_cnt     <= '0;
            FREQ_OK      <= 1'b0;
            FAULT        <= 1'b0;
            COUNT_VALID  <= 1'b0;
            EDGE_COUNT   <= '0;
        end else begin
            {s1, s2, s3} <= {MON_CLK, s1, s2};
            state        <= state_nx;
            win_cnt      <= win_nx;
            edge_cnt     <= edge_nx;
            good_cnt     <= good_nx;
            FREQ_OK      <= ok_nx;
            FAULT        <= fault_nx;
            COUNT_VALID  <= report;
            if (report)
                EDGE_COUNT <= total;
        end
    end
endmodule

// File: tb/tb_osc_freq_monitor.sv
// tb_osc_freq_monitor: random and directed stimulus against an arithmetic window model,
// run on a 16-bit and a 4-bit counter instance sharing the same inputs.
module tb_osc_freq_monitor;
    localparam int WINDOW = 1000;

    logic CLK = 0, RESETN = 0, MON_CLK = 0, ENABLE = 0, CLR_FAULT = 0;
    logic ok_a, fault_a, valid_a, ok_b, fault_b, valid_b;
    logic [15:0] count_a;
    logic [3:0] count_b;

    osc_freq_monitor dut_a (
        .CLK(CLK), .RESETN(RESETN), .MON_CLK(MON_CLK), .ENABLE(ENABLE), .CLR_FAULT(CLR_FAULT),
        .FREQ_OK(ok_a), .FAULT(fault_a), .COUNT_VALID(valid_a), .EDGE_COUNT(count_a)
    );
    osc_freq_monitor #(.CNT_W(4)) dut_b (
        .CLK(CLK), .RESETN(RESETN), .MON_CLK(MON_CLK), .ENABLE(ENABLE), .CLR_FAULT(CLR_FAULT),
        .FREQ_OK(ok_b), .FAULT(fault_b), .COUNT_VALID(valid_b), .EDGE_COUNT(count_b)
    );

    always #10 CLK = ~CLK;

    int n_cmp = 0, n_bad = 0;

    // MON_CLK source: period in CLK cycles, 0 = stuck at mon_level
    int mon_period = 50, ph = 0;
    logic mon_level = 0;
    always @(negedge CLK) begin
        if (mon_period > 0) begin
            ph = (ph + 1) % mon_period;
            MON_CLK = ph >= mon_period / 2;
        end else
            MON_CLK = mon_level;
    end

    // reference model: index 0 = 16-bit instance, 1 = 4-bit instance
    bit p1, p2, p3, e, set;
    int m_mode[2], m_pos[2], m_cnt[2], m_good[2], m_count[2];
    bit m_ok[2], m_fault[2], m_valid[2];
    int tot, rep, sat;

    always @(posedge CLK) begin
        if (!RESETN) begin
            {p1, p2, p3} = '0;
            for (int k = 0; k < 2; k++) begin
                m_mode[k] = 0; m_pos[k] = 0; m_cnt[k] = 0; m_good[k] = 0; m_count[k] = 0;
                m_ok[k] = 0; m_fault[k] = 0; m_valid[k] = 0;
            end
        end else begin
            e = p2 && !p3;  // a rise sampled two cycles ago reaches the counter now
            for (int k = 0; k < 2; k++) begin
                sat = k == 0 ? 65535 : 15;
                set = 0;
                m_valid[k] = 0;
                if (!ENABLE) begin
                    m_mode[k] = 0; m_pos[k] = 0; m_cnt[k] = 0; m_good[k] = 0; m_ok[k] = 0;
                end else if (m_mode[k] == 0) begin
                    m_mode[k] = 1;
                end else begin
                    tot = m_cnt[k] + int'(e);
                    if (m_pos[k] == WINDOW - 1) begin
                        if (m_mode[k] == 2) begin
                            rep = tot > sat ? sat : tot;
                            m_valid[k] = 1;
                            m_count[k] = rep;
                            if (rep >= 18 && rep <= 22) begin
                                m_good[k] = m_good[k] < 3 ? m_good[k] + 1 : 3;
                                m_ok[k] = m_good[k] == 3;
                            end else begin
                                m_good[k] = 0; m_ok[k] = 0; m_fault[k] = 1; set = 1;
                            end
                        end
                        m_mode[k] = 2; m_pos[k] = 0; m_cnt[k] = 0;
                    end else begin
                        m_pos[k]++;
                        m_cnt[k] = tot;
                    end
                end
                if (CLR_FAULT && !set)
                    m_fault[k] = 0;
            end
            p3 = p2; p2 = p1; p1 = MON_CLK;
        end
    end

    always @(negedge CLK) begin
        if (RESETN) begin
            n_cmp++;
            if (valid_a !== m_valid[0] || ok_a !== m_ok[0] || fault_a !== m_fault[0] || int'(count_a) != m_count[0]) begin
                n_bad++;
                $display("FAIL model_a t=%0t got v/ok/f/cnt=%b/%b/%b/%0d want %b/%b/%b/%0d", $time,
                         valid_a, ok_a, fault_a, count_a, m_valid[0], m_ok[0], m_fault[0], m_count[0]);
            end
            n_cmp++;
            if (valid_b !== m_valid[1] || ok_b !== m_ok[1] || fault_b !== m_fault[1] || int'(count_b) != m_count[1]) begin
                n_bad++;
                $display("FAIL model_b t=%0t got v/ok/f/cnt=%b/%b/%b/%0d want %b/%b/%b/%0d", $time,
                         valid_b, ok_b, fault_b, count_b, m_valid[1], m_ok[1], m_fault[1], m_count[1]);
            end
        end
    end

    task automatic chk(input string nm, input int act, input int lo, input int hi);
        n_cmp++;
        if (act < lo || act > hi) begin
            n_bad++;
            $display("FAIL %s: got %0d, want %0d..%0d", nm, act, lo, hi);
        end
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        do begin
            @(negedge CLK);
            n++;
        end while (!valid_a && n < 3000);
        chk("valid_seen", int'(valid_a), 1, 1);
    endtask

    task automatic clr_pulse();
        CLR_FAULT = 1;
        @(negedge CLK);
        CLR_FAULT = 0;
    endtask

    int n, saved, nv;

    initial begin
        repeat (3) @(negedge CLK);
        chk("rst_ok", int'(ok_a), 0, 0);
        chk("rst_fault", int'(fault_a), 0, 0);
        chk("rst_valid", int'(valid_a), 0, 0);
        chk("rst_count", int'(count_a), 0, 0);
        @(posedge CLK); #2 RESETN = 1;

        // nominal 1 MHz: one settle window, then three measured windows
        @(negedge CLK); ENABLE = 1;
        wait_valid(n);
        chk("settle_latency", n, 2001, 2001);
        chk("ok_1st", int'(ok_a), 0, 0);
        chk("count_1st", int'(count_a), 19, 21);
        wait_valid(n);
        chk("ok_2nd", int'(ok_a), 0, 0);
        wait_valid(n);
        chk("ok_3rd", int'(ok_a), 1, 1);
        chk("count_3rd", int'(count_a), 19, 21);
        chk("fault_nominal", int'(fault_a), 0, 0);
        chk("count_sat4", int'(count_b), 15, 15);
        chk("fault_sat4", int'(fault_b), 1, 1);

        // stuck-low oscillator, then recovery with sticky fault
        mon_period = 0; mon_level = 0;
        wait_valid(n); wait_valid(n);
        chk("stuck_count", int'(count_a), 0, 0);
        chk("stuck_ok", int'(ok_a), 0, 0);
        chk("stuck_fault", int'(fault_a), 1, 1);
        mon_period = 50;
        wait_valid(n); wait_valid(n);
        chk("fault_sticky", int'(fault_a), 1, 1);
        repeat (100) @(negedge CLK);
        clr_pulse();
        chk("fault_cleared", int'(fault_a), 0, 0);

        // 2 MHz is too fast; 0.9 MHz is on the lower boundary
        mon_period = 25;
        wait_valid(n); wait_valid(n);
        chk("fast_count", int'(count_a), 40, 40);
        chk("fast_fault", int'(fault_a), 1, 1);
        mon_period = 55;
        wait_valid(n); wait_valid(n);
        clr_pulse();
        wait_valid(n);
        chk("slow_count", int'(count_a), 18, 19);
        chk("slow_fault", int'(fault_a), 0, 0);

        // clear coinciding with an out-of-range window end
        mon_period = 25;
        wait_valid(n); wait_valid(n);
        repeat (500) @(negedge CLK);
        clr_pulse();
        chk("clr_mid", int'(fault_a), 0, 0);
        repeat (498) @(negedge CLK);
        CLR_FAULT = 1;
        @(negedge CLK);
        chk("end_aligned", int'(valid_a), 1, 1);
        chk("clr_vs_set", int'(fault_a), 1, 1);
        @(negedge CLK);
        CLR_FAULT = 0;
        chk("clr_after", int'(fault_a), 0, 0);

        // ENABLE dropped mid-window
        mon_period = 50;
        repeat (4) wait_valid(n);
        chk("ok_before_drop", int'(ok_a), 1, 1);
        saved = int'(count_a);
        repeat (500) @(negedge CLK);
        ENABLE = 0;
        @(negedge CLK);
        chk("drop_ok", int'(ok_a), 0, 0);
        chk("drop_count", int'(count_a), saved, saved);
        nv = 0;
        repeat (1500) begin
            @(negedge CLK);
            if (valid_a) nv++;
        end
        chk("idle_no_valid", nv, 0, 0);
        ENABLE = 1;
        wait_valid(n);
        chk("resettle_latency", n, 2001, 2001);

        // asynchronous reset in the middle of a window
        repeat (300) @(negedge CLK);
        @(posedge CLK); #3 RESETN = 0;
        #1;
        chk("arst_count", int'(count_a), 0, 0);
        chk("arst_count4", int'(count_b), 0, 0);
        chk("arst_fault4", int'(fault_b), 0, 0);
        chk("arst_valid", int'(valid_a), 0, 0);
        repeat (2) @(posedge CLK);
        #2 RESETN = 1;

        // random oscillator rates, clears and enable toggles
        for (int i = 0; i < 14; i++) begin
            @(negedge CLK);
            ENABLE = 1;
            mon_level = 1'($urandom_range(0, 1));
            mon_period = $urandom_range(0, 5) == 0 ? 0 : $urandom_range(0, 2) == 0 ? 50 : $urandom_range(18, 70);
            repeat (1000) begin
                @(negedge CLK);
                CLR_FAULT = $urandom_range(0, 149) == 0;
                if ($urandom_range(0, 2999) == 0) ENABLE = ~ENABLE;
            end
        end
        CLR_FAULT = 0;
        repeat (5) @(negedge CLK);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
